// File: rtl/intdiv_seqdiv.sv
// Multicycle restoring radix-2 signed/unsigned divider with valid/ready handshakes.
// Optional divide-by-zero flag port enabled by defining INTDIV_DBZ_FLAG_EN.
module intdiv_seqdiv #(
   parameter int N = 8,
   localparam int CNTW = $clog2(N) + 1
) (
   input  logic         clock,
   input  logic         resetn,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         in_sgn,
   input  logic [N-1:0] x,
   input  logic [N-1:0] y,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] z,
`ifdef INTDIV_DBZ_FLAG_EN
   output logic         dbz,
`endif
   output logic [N-1:0] r
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_PREP = 3'd1;
   localparam logic [2:0] S_ITER = 3'd2;
   localparam logic [2:0] S_FIX  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   logic [2:0]      state;
   logic [CNTW-1:0] cnt;
   logic [N-1:0]    x_q;      // original dividend, also the divide-by-zero remainder
   logic [N-1:0]    y_q;
   logic            sgn_q;
   logic [N-1:0]    dq;       // dividend bits shift out MSB-first, quotient bits shift in
   logic [N-1:0]    y_abs;
   logic [N-1:0]    rem;
   logic            qneg;
   logic            rneg;
   logic            y_zero;

   logic [N:0]      rem_sh;
   logic            trial_ge;
   logic [N-1:0]    rem_next;

   // The running remainder is always below |y|, so N bits hold it; only the
   // shifted trial value needs the extra bit.
   always_comb begin
      rem_sh   = {rem, dq[N-1]};
      trial_ge = (rem_sh >= {1'b0, y_abs});
      rem_next = trial_ge ? N'(rem_sh - {1'b0, y_abs}) : rem_sh[N-1:0];
   end

   assign in_ready = (state == S_IDLE);

   // NOTE: every register here is sequential state, so the block uses only
   // non-blocking assignments; blocking ones would create order-dependent races.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state     <= S_IDLE;
         cnt       <= '0;
         x_q       <= '0;
         y_q       <= '0;
         sgn_q     <= 1'b0;
         dq        <= '0;
         y_abs     <= '0;
         rem       <= '0;
         qneg      <= 1'b0;
         rneg      <= 1'b0;
         y_zero    <= 1'b0;
         out_valid <= 1'b0;
         z         <= '0;
         r         <= '0;
`ifdef INTDIV_DBZ_FLAG_EN
         dbz       <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  x_q   <= x;
                  y_q   <= y;
                  sgn_q <= in_sgn;
                  state <= S_PREP;
               end
            end

            S_PREP: begin
               if (sgn_q) begin
                  dq    <= x_q[N-1] ? -x_q : x_q;
                  y_abs <= y_q[N-1] ? -y_q : y_q;
                  qneg  <= x_q[N-1] ^ y_q[N-1];
                  rneg  <= x_q[N-1];
               end else begin
                  dq    <= x_q;
                  y_abs <= y_q;
                  qneg  <= 1'b0;
                  rneg  <= 1'b0;
               end
               rem    <= '0;
               cnt    <= CNTW'(N);
               y_zero <= (y_q == '0);
               state  <= (y_q == '0) ? S_FIX : S_ITER;
            end

            S_ITER: begin
               rem <= rem_next;
               dq  <= {dq[N-2:0], trial_ge};
               cnt <= cnt - CNTW'(1);
               if (cnt == CNTW'(1)) begin
                  state <= S_FIX;
               end
            end

            S_FIX: begin
               if (y_zero) begin
                  z <= '1;
                  r <= x_q;
               end else begin
                  z <= qneg ? -dq : dq;
                  r <= rneg ? -rem : rem;
               end
`ifdef INTDIV_DBZ_FLAG_EN
               dbz       <= y_zero;
`endif
               out_valid <= 1'b1;
               state     <= S_DONE;
            end

            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
